// File: rtl/hex_scan_pkg.sv
// Shared constants and types for the multiplexed hex seven-segment scanner.
// Segment encodings are active-low, bit0 = a ... bit6 = g.
package hex_scan_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Index n holds the glyph for hex digit n (entry 0 is the rightmost element).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Everything that must stay coherent for a whole frame.
  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic        blank_lz;
  } shadow_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment lookup.
module hex7seg_decode
  import hex_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// 8-digit common-anode hex scanner with frame shadowing, leading-zero
// blanking, decimal points, 8-level PWM and a dead cycle at each digit switch.
module hex_scan_display
  import hex_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  input  logic [2:0]  bright,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n
);

  localparam int unsigned PW   = $clog2(SCAN_DIV);
  localparam int unsigned LW   = PW + 1;
  localparam int unsigned SLOT = SCAN_DIV / 8;

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  shadow_t       shd;
  logic          pre_wrap;
  logic          frame_wrap;

  assign pre_wrap   = (pre == PW'(SCAN_DIV - 1));
  assign frame_wrap = pre_wrap && (idx == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
      shd <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + 1'b1;
      if (pre_wrap) idx <= idx + 3'd1;
      // Shadow load shares the edge with the 7->0 wrap, so digit 0 of the
      // new frame already sees the new sample.
      if (frame_wrap) shd <= '{value: value, dp_mask: dp_mask, blank_lz: blank_lz};
    end
  end

  logic [3:0] nibble;
  logic [6:0] glyph_n;

  assign nibble = shd.value[{idx, 2'b00} +: 4];

  hex7seg_decode u_decode (
    .nibble (nibble),
    .seg_n  (glyph_n)
  );

  // blank_mask[i] is set when nibbles 7..i are all zero; digit 0 never blanks.
  logic [7:0] blank_mask;
  logic       zero_run;

  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = 7; i >= 1; i--) begin
      zero_run      = zero_run & (shd.value[4*i +: 4] == 4'h0);
      blank_mask[i] = zero_run & shd.blank_lz;
    end
  end

  // sub <= bright is the same as pre < (bright+1)*SLOT, which avoids a divider.
  logic [LW-1:0] on_limit;
  logic          digit_on;

  assign on_limit = LW'((32'(bright) + 32'd1) * SLOT);
  assign digit_on = (pre != '0) && ({1'b0, pre} < on_limit);

  logic [7:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (digit_on) begin
      an_next = ~(8'h01 << idx);
      if (!blank_mask[idx]) begin
        seg_next = glyph_n;
        dp_next  = ~shd.dp_mask[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= AN_OFF;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_next;
      seg_n <= seg_next;
      dp_n  <= dp_next;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with SCAN_DIV = 16 (128-cycle frames).
module tb_hex_scan_display;

  localparam int unsigned SCAN_DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = 32'h0;
  logic [7:0]  dp_mask = 8'h00;
  logic        blank_lz = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;

  hex_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .bright   (bright),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;  // rising edges since the last reset release

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Output after edge t reflects state t-1: pre=(t-1)%16, idx=((t-1)/16)%8.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    t += n;
    #1;
  endtask

  task automatic advance_to(input int target);
    if (target > t) tick(target - t);
  endtask

  task automatic goto(input int frame, input int digit, input int p);
    advance_to(frame * 128 + digit * 16 + p + 1);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] an, input logic [6:0] seg, input logic dp);
    check({tag, "_an"}, 32'(an_n), 32'(an));
    check({tag, "_seg"}, 32'(seg_n), 32'(seg));
    check({tag, "_dp"}, 32'(dp_n), 32'(dp));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
  endtask

  int lows;
  int dps;

  initial begin
    // Reset then basic scan
    value = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    expect_out("in_reset", 8'hFF, 7'h7F, 1'b1);
    release_reset();
    tick(1);
    expect_out("first_dead", 8'hFF, 7'h7F, 1'b1);
    tick(1);
    expect_out("frame0_d0", 8'hFE, 7'h40, 1'b1);

    advance_to(128);
    lows = 0;
    for (int p = 0; p < 16; p++) begin
      tick(1);
      if (p == 0) expect_out("f1_d0_dead", 8'hFF, 7'h7F, 1'b1);
      if (p == 1) check("f1_d0_seg", 32'(seg_n), 32'h00);
      if (an_n == 8'hFE) lows++;
    end
    check("f1_d0_on_cycles", lows, 15);
    goto(1, 7, 5);
    expect_out("f1_d7", 8'h7F, 7'h79, 1'b1);

    // Leading-zero blanking
    value = 32'h000000A5;
    blank_lz = 1'b1;
    goto(2, 0, 3); expect_out("lz_d0", 8'hFE, 7'h12, 1'b1);
    goto(2, 1, 3); expect_out("lz_d1", 8'hFD, 7'h08, 1'b1);
    goto(2, 2, 3); expect_out("lz_d2", 8'hFB, 7'h7F, 1'b1);
    goto(2, 5, 3); expect_out("lz_d5", 8'hDF, 7'h7F, 1'b1);
    goto(2, 7, 3); expect_out("lz_d7", 8'h7F, 7'h7F, 1'b1);
    value = 32'h0;
    goto(3, 0, 3); expect_out("zero_d0", 8'hFE, 7'h40, 1'b1);
    goto(3, 1, 3); expect_out("zero_d1", 8'hFD, 7'h7F, 1'b1);
    goto(3, 4, 8); expect_out("zero_d4", 8'hEF, 7'h7F, 1'b1);

    // Tearing: mid-frame change must not show until the next frame
    value = 32'h11111111;
    blank_lz = 1'b0;
    goto(4, 3, 1);
    value = 32'hFFFFFFFF;
    goto(4, 3, 4); expect_out("tear_d3", 8'hF7, 7'h79, 1'b1);
    goto(4, 7, 4); expect_out("tear_d7", 8'h7F, 7'h79, 1'b1);
    goto(5, 0, 2); expect_out("next_d0", 8'hFE, 7'h0E, 1'b1);
    goto(5, 6, 2); expect_out("next_d6", 8'hBF, 7'h0E, 1'b1);

    // Brightness 0 over frame 6, then 3 over frame 7
    bright = 3'd0;
    advance_to(6 * 128);
    for (int d = 0; d < 8; d++) begin
      lows = 0;
      for (int p = 0; p < 16; p++) begin
        tick(1);
        if (p == 0) check("b0_dead", 32'(an_n), 32'hFF);
        check("b0_onehot", ($countones(~an_n) <= 1), 1);
        if (an_n[d] == 1'b0) lows++;
      end
      check("b0_on_cycles", lows, 1);
    end
    bright = 3'd3;
    dp_mask = 8'h81;
    for (int d = 0; d < 8; d++) begin
      lows = 0;
      for (int p = 0; p < 16; p++) begin
        tick(1);
        if (p == 0) check("b3_dead", 32'(an_n), 32'hFF);
        check("b3_onehot", ($countones(~an_n) <= 1), 1);
        if (an_n[d] == 1'b0) lows++;
      end
      check("b3_on_cycles", lows, 7);
    end

    // Decimal points on digits 0 and 7 over frame 8
    bright = 3'd7;
    for (int d = 0; d < 8; d++) begin
      dps = 0;
      for (int p = 0; p < 16; p++) begin
        tick(1);
        if (p == 0) check("dp_dead", 32'(dp_n), 32'h1);
        if (dp_n == 1'b0) dps++;
      end
      check("dp_cycles", dps, (d == 0 || d == 7) ? 15 : 0);
    end

    // Mid-frame asynchronous reset at idx 5
    goto(9, 5, 3);
    expect_out("pre_rst", 8'hDF, 7'h0E, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 8'hFF, 7'h7F, 1'b1);
    repeat (2) @(posedge clk);
    release_reset();
    tick(1);
    expect_out("rst2_dead", 8'hFF, 7'h7F, 1'b1);
    tick(1);
    expect_out("rst2_d0", 8'hFE, 7'h40, 1'b1);
    goto(0, 3, 2);
    expect_out("rst2_d3", 8'hF7, 7'h40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
